cnff_bank: RTL

CNFF_BANK -- requirements
Module: cnff_bank

---
 rtl/cnff_bank.sv | 82 ++++++++
 1 files changed

// File: rtl/cnff_bank.sv
// Bank of WIDTH change/no-change flip-flops with CNFF, load, shift and rotate modes,
// plus a registered change flag and a saturating change-event counter.
module cnff_bank #(
   parameter int unsigned         WIDTH = 8,
   parameter int unsigned         CNT_W = 8,
   parameter logic [WIDTH-1:0]    INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] n,
   input  logic [WIDTH-1:0] c,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] out,
   output logic             changed,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam logic [1:0] MODE_CNFF   = 2'b00;
   localparam logic [1:0] MODE_LOAD   = 2'b01;
   localparam logic [1:0] MODE_SHIFT  = 2'b10;
   localparam logic [1:0] MODE_ROTATE = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] out_q, out_d;
   logic             changed_q, changed_d;
   logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
   logic             any_chg;

   // Per-bit next value; shift/rotate sources always come from the pre-edge out_q.
   always_comb begin
      out_d = out_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (n[i]) begin
            case (mode)
               MODE_CNFF:  out_d[i] = c[i] & ~out_q[i];
               MODE_LOAD:  out_d[i] = d[i];
               MODE_SHIFT: begin
                  if (i == 0) out_d[i] = si;
                  else        out_d[i] = out_q[i-1];
               end
               default: begin
                  if (i == 0) out_d[i] = out_q[WIDTH-1];
                  else        out_d[i] = out_q[i-1];
               end
            endcase
         end
      end
   end

   assign any_chg = (out_d != out_q);

   always_comb begin
      changed_d = any_chg;
      chg_cnt_d = chg_cnt_q;
      if (clr_cnt) begin
         chg_cnt_d = '0;
      end else if (any_chg && (chg_cnt_q != CNT_MAX)) begin
         chg_cnt_d = chg_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= INIT;
         changed_q <= 1'b0;
         chg_cnt_q <= '0;
      end else begin
         out_q     <= out_d;
         changed_q <= changed_d;
         chg_cnt_q <= chg_cnt_d;
      end
   end

   assign out     = out_q;
   assign changed = changed_q;
   assign chg_cnt = chg_cnt_q;

endmodule
